dmem_byte_ctrl: RTL and testbench
=================================

// Module: dmem_byte_ctrl
// PURPOSE
//  Parametrised data memory for the pipeline MEM stage; next generation of the 32-word data store.
//  Supports byte/half/word loads and stores, sign/zero-extended loads, registered one-cycle reads and
//  misalignment/range error flags.
//  Memory is cleared by a post-reset sweep FSM instead of asynchronously resetting every word.
// PARAMETERS
//  DEPTH    256  number of 32-bit words; power of two, >=2
//  IDX_W    $clog2(DEPTH)  word-index width (derived, not overridden)
// PORTS
//  clk           in   1   system clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  req_valid     in   1   access request this cycle
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   00=byte, 01=half, 10=word, 11=reserved
//  req_unsigned  in   1   load zero-extends when 1, sign-extends when 0
//  address       in   32  byte address
//  write_data    in   32  store data; byte/half taken from bits [7:0]/[15:0]
//  req_ready     out  1   accepting requests (state READY)
//  busy          out  1   clear sweep in progress (state INIT)
//  rdata_valid   out  1   1-cycle pulse: data_out carries load result
//  data_out      out  32  load result, held until the next load completes
//  misalign      out  1   1-cycle pulse: previous accepted request misaligned or reserved size
//  out_of_range  out  1   1-cycle pulse: previous accepted request beyond DEPTH
// BEHAVIOUR
//  Reset (async, rst_n=0): state=INIT, sweep index=0. Outputs: req_ready=0, busy=1, rdata_valid=0,
//    data_out=0, misalign=0, out_of_range=0. Memory contents are not reset by rst_n itself.
//  Reset asserted mid-sweep or mid-access restarts the sweep at index 0; any in-flight load is dropped.
//  INIT: each cycle writes word[idx]=0, idx++. After idx==DEPTH-1 is written -> READY.
//    Sweep takes exactly DEPTH cycles. Requests during INIT are ignored; no flags are raised.
//  READY: req_ready=1, busy=0. A request is accepted when req_valid && req_ready.
//    One access per cycle, no back-pressure.
//  Decode: word index = address[IDX_W+1:2]. Range error if address[31:IDX_W+2] != 0.
//  Alignment: half requires address[0]==0; word requires address[1:0]==0; size 11 is always an error.
//    If both errors apply, misalign has priority; out_of_range stays 0.
//  Store (no error): written at the accepting edge through byte lanes.
//    Byte: lane address[1:0] gets write_data[7:0].
//    Half: lanes {a1,1},{a1,0} get write_data[15:0], where a1=address[1].
//    Word: all lanes written. Unwritten lanes are unchanged. No rdata_valid.
//  Load: word read at the accepting edge. Next cycle: rdata_valid=1 and data_out = selected byte/half/word.
//    Byte/half are sign- or zero-extended per req_unsigned; word ignores req_unsigned. Latency 1.
//  Error (either flag): memory is not modified. Flag pulses the cycle after acceptance.
//    If the request was a load, rdata_valid also pulses with data_out=0.
//  Store at edge N, load of the same word at edge N+1: load returns the new data (no forwarding needed).
//  Index wrap: none; addresses beyond DEPTH are flagged, never aliased.
//  rdata_valid, misalign and out_of_range are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Package dmem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum {INIT, READY}, byte-lane mask type.
//  Sub-module dmem_lane_align (combinational):
//    Store side: lane mask and data replication.
//    Load side: byte/half extraction and extension.
//    Top level holds the array, FSM, sweep counter and output registers.
// TESTING
//  1 Reset, DEPTH=256 -> busy=1 for exactly 256 cycles, then req_ready=1; loads at 0x000 and 0x3FC return 0.
//  2 SW 0x80FF_7F01 @0x10; then LB @0x10/0x11/0x13 and LBU @0x13.
//      Expect 0x00000001, 0x0000007F, 0xFFFFFF80, 0x00000080, each with rdata_valid one cycle after acceptance.
//  3 SB 0xAB @0x22 over word 0 -> LW @0x20 = 0x00AB0000.
//    SH 0xBEEF @0x20 -> LW = 0x00ABBEEF; LH = 0xFFFFBEEF; LHU = 0x0000BEEF.
//  4 LW @0x12 -> misalign pulse, data_out=0.
//    SH @0x11 with data 0x1234 -> misalign pulse, memory unchanged.
//    Size 11 -> misalign pulse.
//  5 SW @0x400 (DEPTH=256) -> out_of_range pulse, word 0 unchanged.
//    LW @0x402 -> misalign=1, out_of_range=0.
//  6 Assert rst_n low at sweep cycle 100 and mid-load.
//    -> outputs return to reset values immediately; after release the full 256-cycle sweep re-runs and no rdata_valid appears.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the byte-addressable data memory: access sizes, controller states, lane masks.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  typedef logic [3:0] lane_mask_t;

  // Reserved size is always an error; halves need even, words need 4-byte aligned addresses.
  function automatic logic size_misaligned(size_e sz, logic [1:0] offs);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offs[0];
      SZ_WORD: return offs != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store-side lane mask and data replication, load-side extraction and extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       st_size,
  input  logic [1:0]  st_offs,
  input  logic [31:0] st_wdata,
  output lane_mask_t  st_mask,
  output logic [31:0] st_data,
  input  size_e       ld_size,
  input  logic [1:0]  ld_offs,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_mask = '0;
    st_data = st_wdata;
    case (st_size)
      SZ_BYTE: begin
        st_mask = lane_mask_t'(4'b0001 << st_offs);
        st_data = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_mask = st_offs[1] ? 4'b1100 : 4'b0011;
        st_data = {2{st_wdata[15:0]}};
      end
      SZ_WORD: st_mask = 4'b1111;
      default: st_mask = '0;
    endcase
  end

  always_comb begin
    ld_byte = ld_word[{ld_offs, 3'b000} +: 8];
    ld_half = ld_offs[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_byte_ctrl.sv
// MEM-stage data memory: byte/half/word access with registered reads, error flags and a
// post-reset clear sweep.
module dmem_byte_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        req_ready,
  output logic        busy,
  output logic        rdata_valid,
  output logic [31:0] data_out,
  output logic        misalign,
  output logic        out_of_range
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_idx_q;
  logic [31:0]      mem [DEPTH];

  logic             accept, size_err, range_err, store_ok;
  logic [IDX_W-1:0] word_idx;
  size_e            size_in;
  lane_mask_t       st_mask;
  logic [31:0]      st_data, ld_data;

  logic [31:0]      rd_word_q;
  size_e            ld_size_q;
  logic [1:0]       ld_offs_q;
  logic             ld_uns_q, ld_zero_q;
  logic             rdata_valid_q, misalign_q, oor_q;

  assign size_in   = size_e'(req_size);
  assign word_idx  = address[IDX_W+1:2];
  assign size_err  = size_misaligned(size_in, address[1:0]);
  assign range_err = |address[31:IDX_W+2];
  assign accept    = req_valid & req_ready;
  assign store_ok  = accept & req_we & ~size_err & ~range_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (sweep_idx_q == IDX_W'(DEPTH - 1)) state_d = READY;
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    req_ready = (state_q == READY);
    busy      = (state_q == INIT);
  end

  dmem_lane_align u_lane_align (
    .st_size     (size_in),
    .st_offs     (address[1:0]),
    .st_wdata    (write_data),
    .st_mask     (st_mask),
    .st_data     (st_data),
    .ld_size     (ld_size_q),
    .ld_offs     (ld_offs_q),
    .ld_unsigned (ld_uns_q),
    .ld_word     (rd_word_q),
    .ld_data     (ld_data)
  );

  // Array has no reset; the sweep clears it. rd_word_q is masked by ld_zero_q until a good load.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[sweep_idx_q] <= '0;
    end else if (store_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (st_mask[i]) mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
    if (accept && !req_we) rd_word_q <= mem[word_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_idx_q   <= '0;
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      oor_q         <= 1'b0;
      ld_size_q     <= SZ_WORD;
      ld_offs_q     <= 2'b00;
      ld_uns_q      <= 1'b0;
      ld_zero_q     <= 1'b1;
    end else begin
      if (state_q == INIT) sweep_idx_q <= sweep_idx_q + 1'b1;
      rdata_valid_q <= accept & ~req_we;
      misalign_q    <= accept & size_err;
      oor_q         <= accept & range_err & ~size_err;
      if (accept && !req_we) begin
        ld_size_q <= size_in;
        ld_offs_q <= address[1:0];
        ld_uns_q  <= req_unsigned;
        ld_zero_q <= size_err | range_err;
      end
    end
  end

  assign rdata_valid  = rdata_valid_q;
  assign misalign     = misalign_q;
  assign out_of_range = oor_q;
  assign data_out     = ld_zero_q ? '0 : ld_data;

endmodule

// File: tb/tb_dmem_byte_ctrl.sv
// Self-checking bench for dmem_byte_ctrl: directed cases plus random traffic against a byte-array model.
module tb_dmem_byte_ctrl;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned NBYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic        req_ready, busy, rdata_valid, misalign, out_of_range;
  logic [31:0] data_out;

  logic [7:0]  ref_mem [NBYTES];
  logic [31:0] exp_dout;
  int          n_checks = 0;
  int          n_errors = 0;

  dmem_byte_ctrl #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .address      (address),
    .write_data   (write_data),
    .req_ready    (req_ready),
    .busy         (busy),
    .rdata_valid  (rdata_valid),
    .data_out     (data_out),
    .misalign     (misalign),
    .out_of_range (out_of_range)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic ref_misalign(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction

  // Little-endian read of the byte model, extended as the size/sign rules ask.
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a);
    int i;
    logic [7:0]  b;
    logic [15:0] h;
    i = int'(a);
    b = ref_mem[i];
    if (sz == 2'd0) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == 2'd1) begin
      h = {ref_mem[i+1], ref_mem[i]};
      return uns ? {16'h0, h} : {{16{h[15]}}, h};
    end
    return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
  endfunction

  task automatic access(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    logic mis, oor, ok;
    logic [31:0] ld;
    int i;
    mis = v && ref_misalign(sz, a);
    oor = v && !mis && (a >= NBYTES);
    ok  = v && !mis && !oor;
    ld  = '0;
    i   = int'(a);
    if (ok && !we) ld = ref_load(sz, uns, a);
    if (ok && we) begin
      ref_mem[i] = wd[7:0];
      if (sz != 2'd0) ref_mem[i+1] = wd[15:8];
      if (sz == 2'd2) begin
        ref_mem[i+2] = wd[23:16];
        ref_mem[i+3] = wd[31:24];
      end
    end
    req_valid = v; req_we = we; req_size = sz; req_unsigned = uns;
    address = a; write_data = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (v && !we) exp_dout = ld;
    check_eq("rdata_valid", {31'b0, rdata_valid}, {31'b0, v && !we});
    check_eq("misalign", {31'b0, misalign}, {31'b0, mis});
    check_eq("out_of_range", {31'b0, out_of_range}, {31'b0, oor});
    check_eq("data_out", data_out, exp_dout);
    check_eq("req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic load_expect(input string tag, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] exp);
    access(1'b1, 1'b0, sz, uns, a, '0);
    check_eq(tag, data_out, exp);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
    check_eq({tag, "_busy"}, {31'b0, busy}, 32'd1);
    check_eq({tag, "_rdata_valid"}, {31'b0, rdata_valid}, 32'd0);
    check_eq({tag, "_data_out"}, data_out, 32'd0);
    check_eq({tag, "_misalign"}, {31'b0, misalign}, 32'd0);
    check_eq({tag, "_out_of_range"}, {31'b0, out_of_range}, 32'd0);
  endtask

  // Called right after rst_n is released on a falling edge; counts cycles until req_ready.
  task automatic run_sweep(input string tag);
    int cnt, bad;
    cnt = 0;
    bad = 0;
    while (cnt < 1000) begin
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3;
      address = 32'h0000_1000;
      @(negedge clk);
      cnt++;
      if (req_ready) break;
      if (!busy || rdata_valid || misalign || out_of_range) bad++;
    end
    req_valid = 1'b0;
    check_eq({tag, "_sweep_len"}, 32'(cnt), 32'(DEPTH));
    check_eq({tag, "_sweep_quiet"}, 32'(bad), 32'd0);
    for (int k = 0; k < int'(NBYTES); k++) ref_mem[k] = 8'h00;
    exp_dout = '0;
  endtask

  initial begin
    logic        v, we, uns;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    int          r;
    exp_dout = '0;

    // 1: power-on reset and sweep
    #12;
    check_reset_outs("por");
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep("por");
    load_expect("t1_lw_000", 2'd2, 1'b0, 32'h000, 32'h0);
    load_expect("t1_lw_3fc", 2'd2, 1'b0, 32'h3FC, 32'h0);

    // 2: word store, byte loads
    access(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF_7F01);
    load_expect("t2_lb_10", 2'd0, 1'b0, 32'h10, 32'h0000_0001);
    load_expect("t2_lb_11", 2'd0, 1'b0, 32'h11, 32'h0000_007F);
    load_expect("t2_lb_13", 2'd0, 1'b0, 32'h13, 32'hFFFF_FF80);
    load_expect("t2_lbu_13", 2'd0, 1'b1, 32'h13, 32'h0000_0080);

    // 3: partial stores
    access(1'b1, 1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AB);
    load_expect("t3_lw_a", 2'd2, 1'b0, 32'h20, 32'h00AB_0000);
    access(1'b1, 1'b1, 2'd1, 1'b0, 32'h20, 32'h0000_BEEF);
    load_expect("t3_lw_b", 2'd2, 1'b0, 32'h20, 32'h00AB_BEEF);
    load_expect("t3_lh", 2'd1, 1'b0, 32'h20, 32'hFFFF_BEEF);
    load_expect("t3_lhu", 2'd1, 1'b1, 32'h20, 32'h0000_BEEF);

    // 4: misalignment and reserved size
    load_expect("t4_lw_12_data", 2'd2, 1'b0, 32'h12, 32'h0);
    check_eq("t4_lw_12_mis", {31'b0, misalign}, 32'd1);
    access(1'b1, 1'b1, 2'd1, 1'b0, 32'h11, 32'h0000_1234);
    check_eq("t4_sh_11_mis", {31'b0, misalign}, 32'd1);
    load_expect("t4_unchanged", 2'd2, 1'b0, 32'h10, 32'h80FF_7F01);
    access(1'b1, 1'b0, 2'd3, 1'b0, 32'h20, '0);
    check_eq("t4_rsvd_mis", {31'b0, misalign}, 32'd1);

    // 5: out of range
    access(1'b1, 1'b1, 2'd2, 1'b0, 32'h400, 32'hFFFF_FFFF);
    check_eq("t5_sw_400_oor", {31'b0, out_of_range}, 32'd1);
    load_expect("t5_w0_unchanged", 2'd2, 1'b0, 32'h0, 32'h0);
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h402, '0);
    check_eq("t5_lw_402_mis", {31'b0, misalign}, 32'd1);
    check_eq("t5_lw_402_oor", {31'b0, out_of_range}, 32'd0);

    // random traffic, dense in a small window so stores and loads collide
    for (int k = 0; k < 3000; k++) begin
      v   = ($urandom_range(0, 9) != 0);
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 15));
      sz  = (r == 0) ? 2'd3 : 2'(r % 3);
      a   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 63) : $urandom_range(0, NBYTES - 1);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 15) == 0) a = a + NBYTES * $urandom_range(1, 1000);
      wd  = $urandom;
      access(v, we, sz, uns, a, wd);
    end

    // 6a: reset at sweep cycle 100
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst_ready");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outs("mid_sweep");
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep("mid_sweep");

    // 6b: reset with a load in flight
    access(1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h1234_5678);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; address = 32'h40;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check_reset_outs("mid_load");
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep("mid_load");
    load_expect("t6_cleared", 2'd2, 1'b0, 32'h40, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
